// File: rtl/RS5_pkg.sv
// RS5_pkg: shared types for the register-bank write-back arbiter.
//
// Contents:
//   wbarb_state_e - arbiter FSM state (IDLE, HELD, FORCE)
//   WBARB_AGE_W   - width of the held-entry age counter
package RS5_pkg;

  // IDLE  : holding register empty
  // HELD  : holding register full, waiting for a free port cycle
  // FORCE : holding register full and aged out; retire is stalled this cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    FORCE = 2'd2
  } wbarb_state_e;

  localparam int WBARB_AGE_W = 4;

endpackage : RS5_pkg

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the single register-bank write port between the
// in-order retire path (always priority) and the multiply/divide unit. An MDU
// result that cannot be written at once is parked in a one-entry holding
// register; an age counter bounds its wait, after which retire is stalled for
// one cycle so the held result can drain.
//
// Optional feature macro: WB_ARBITER_BYPASS_EN
//   defined   - in IDLE, an rd!=0 MDU transfer with no effective retire write
//               goes straight to the port in the same cycle.
//   undefined - every rd!=0 MDU transfer is captured first (>=1 cycle latency).
//
// Parameters:
//   STARVE_LIMIT           blocked cycles tolerated before forcing a drain (1..15)
// Ports:
//   clk, reset             core clock; asynchronous active-high reset
//   retire_we_i/rd_i/data_i retire write request
//   mdu_valid_i/rd_i/data_i MDU result handshake; mdu_ready_o accepts it
//   stall_o                retire write not performed this cycle
//   regbank_*_o            register bank write port
//   held_valid_o/held_rd_o pending MDU entry, for decode RAW interlock
module writeback_arbiter
  import RS5_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        retire_we_i,
  input  logic [4:0]  retire_rd_i,
  input  logic [31:0] retire_data_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  output logic        stall_o,
  output logic        regbank_write_enable_o,
  output logic [4:0]  regbank_addr_o,
  output logic [31:0] regbank_data_o,
  output logic        held_valid_o,
  output logic [4:0]  held_rd_o
);

  localparam logic [WBARB_AGE_W-1:0] LIMIT = WBARB_AGE_W'(STARVE_LIMIT);

  wbarb_state_e           state_reg, state_next;
  logic [WBARB_AGE_W-1:0] age_reg, age_next;
  logic [4:0]             held_rd_reg, held_rd_next;
  logic [31:0]            held_data_reg, held_data_next;

  logic        retire_eff;
  logic        ready;
  logic        stall;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] data;

  // Writes to x0 are architectural no-ops and never claim the port.
  assign retire_eff = retire_we_i && (retire_rd_i != 5'd0);

  always_comb begin
    state_next     = state_reg;
    age_next       = age_reg;
    held_rd_next   = held_rd_reg;
    held_data_next = held_data_reg;
    ready          = 1'b0;
    stall          = 1'b0;
    we             = 1'b0;
    addr           = 5'd0;
    data           = 32'd0;

    unique case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (retire_eff) begin
          we   = 1'b1;
          addr = retire_rd_i;
          data = retire_data_i;
        end
        // rd==0 transfers are accepted and silently dropped.
        if (mdu_valid_i && (mdu_rd_i != 5'd0)) begin
`ifdef WB_ARBITER_BYPASS_EN
          if (!retire_eff) begin
            we   = 1'b1;
            addr = mdu_rd_i;
            data = mdu_data_i;
          end else begin
            held_rd_next   = mdu_rd_i;
            held_data_next = mdu_data_i;
            age_next       = '0;
            state_next     = HELD;
          end
`else
          held_rd_next   = mdu_rd_i;
          held_data_next = mdu_data_i;
          age_next       = '0;
          state_next     = HELD;
`endif
        end
      end

      HELD: begin
        if (!retire_eff) begin
          we         = 1'b1;
          addr       = held_rd_reg;
          data       = held_data_reg;
          state_next = IDLE;
        end else begin
          we   = 1'b1;
          addr = retire_rd_i;
          data = retire_data_i;
          if (retire_rd_i == held_rd_reg) begin
            // Younger retire write to the same register: held value is dead.
            state_next = IDLE;
          end else begin
            age_next = age_reg + 1'b1;
            if (age_next == LIMIT) begin
              state_next = FORCE;
            end
          end
        end
      end

      FORCE: begin
        we         = 1'b1;
        addr       = held_rd_reg;
        data       = held_data_reg;
        stall      = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      age_reg       <= '0;
      held_rd_reg   <= 5'd0;
      held_data_reg <= 32'd0;
    end else begin
      state_reg     <= state_next;
      age_reg       <= age_next;
      held_rd_reg   <= held_rd_next;
      held_data_reg <= held_data_next;
    end
  end

  // Outputs are held at zero for as long as reset is asserted, not just
  // after the registers have been cleared.
  assign mdu_ready_o            = ready && !reset;
  assign stall_o                = stall && !reset;
  assign regbank_write_enable_o = we && !reset;
  assign regbank_addr_o         = reset ? 5'd0 : addr;
  assign regbank_data_o         = reset ? 32'd0 : data;
  assign held_valid_o           = (state_reg != IDLE) && !reset;
  assign held_rd_o              = held_valid_o ? held_rd_reg : 5'd0;

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed self-checking bench for writeback_arbiter
// (default build, bypass disabled, STARVE_LIMIT=4). Inputs change after the
// falling edge and outputs are sampled 1 time unit later, well away from the
// rising edge. Each check compares a packed snapshot
// {we, addr, data, stall, ready, held_valid, held_rd}.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        retire_we_i;
  logic [4:0]  retire_rd_i;
  logic [31:0] retire_data_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        stall_o;
  logic        regbank_write_enable_o;
  logic [4:0]  regbank_addr_o;
  logic [31:0] regbank_data_o;
  logic        held_valid_o;
  logic [4:0]  held_rd_o;

  int compared   = 0;
  int mismatched = 0;

  writeback_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .retire_we_i            (retire_we_i),
    .retire_rd_i            (retire_rd_i),
    .retire_data_i          (retire_data_i),
    .mdu_valid_i            (mdu_valid_i),
    .mdu_rd_i               (mdu_rd_i),
    .mdu_data_i             (mdu_data_i),
    .mdu_ready_o            (mdu_ready_o),
    .stall_o                (stall_o),
    .regbank_write_enable_o (regbank_write_enable_o),
    .regbank_addr_o         (regbank_addr_o),
    .regbank_data_o         (regbank_data_o),
    .held_valid_o           (held_valid_o),
    .held_rd_o              (held_rd_o)
  );

  always #5 clk = ~clk;

  logic [45:0] obs;
  assign obs = {regbank_write_enable_o, regbank_addr_o, regbank_data_o,
                stall_o, mdu_ready_o, held_valid_o, held_rd_o};

  function automatic logic [45:0] snap(input logic we, input logic [4:0] a,
                                       input logic [31:0] d, input logic st,
                                       input logic rdy, input logic hv,
                                       input logic [4:0] hrd);
    return {we, a, d, st, rdy, hv, hrd};
  endfunction

  // Apply one cycle of inputs after the falling edge, then let them settle.
  task automatic drive(input logic rwe, input logic [4:0] rrd, input logic [31:0] rdat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    @(negedge clk);
    retire_we_i   = rwe;
    retire_rd_i   = rrd;
    retire_data_i = rdat;
    mdu_valid_i   = mv;
    mdu_rd_i      = mrd;
    mdu_data_i    = mdat;
    #1;
  endtask

  task automatic test_reset();
    logic [45:0] exp;
    reset = 1'b1;
    retire_we_i = 1'b1; retire_rd_i = 5'd5; retire_data_i = 32'h11;
    mdu_valid_i = 1'b1; mdu_rd_i = 5'd7; mdu_data_i = 32'hAB;
    #1;
    exp = '0;
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h want=%h", obs, exp);
    end else $display("ok   reset_outputs %h", obs);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp = snap(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL reset_release got=%h want=%h", obs, exp);
    end else $display("ok   reset_release %h", obs);
  endtask

  task automatic test_retire();
    logic [45:0] exp;
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    exp = snap(1'b1, 5'd5, 32'h11, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL retire_write got=%h want=%h", obs, exp);
    end else $display("ok   retire_write %h", obs);
  endtask

  task automatic test_mdu_capture();
    logic [45:0] exp;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAB);
    exp = snap(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL mdu_capture got=%h want=%h", obs, exp);
    end else $display("ok   mdu_capture %h", obs);
    // MDU keeps offering a new result; ready must be low while held.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hCD);
    exp = snap(1'b1, 5'd7, 32'hAB, 1'b0, 1'b0, 1'b1, 5'd7);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL mdu_drain got=%h want=%h", obs, exp);
    end else $display("ok   mdu_drain %h", obs);
    // The x8 offer was not accepted, so nothing is held now.
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp = snap(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL mdu_after_drain got=%h want=%h", obs, exp);
    end else $display("ok   mdu_after_drain %h", obs);
  endtask

  task automatic test_starve();
    logic [45:0] exp;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
      exp = snap(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b0, 1'b1, 5'd7);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL starve_retire_%0d got=%h want=%h", i, obs, exp);
      end else $display("ok   starve_retire_%0d %h", i, obs);
    end
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
    exp = snap(1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b1, 5'd7);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL starve_force got=%h want=%h", obs, exp);
    end else $display("ok   starve_force %h", obs);
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
    exp = snap(1'b1, 5'd5, 32'h55, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL starve_replay got=%h want=%h", obs, exp);
    end else $display("ok   starve_replay %h", obs);
  endtask

  task automatic test_waw();
    logic [45:0] exp;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
    exp = snap(1'b1, 5'd9, 32'h22, 1'b0, 1'b0, 1'b1, 5'd9);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL waw_retire got=%h want=%h", obs, exp);
    end else $display("ok   waw_retire %h", obs);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp = snap(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL waw_squashed got=%h want=%h", obs, exp);
    end else $display("ok   waw_squashed %h", obs);
  endtask

  task automatic test_x0();
    logic [45:0] exp;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5A);
    exp = snap(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL mdu_x0_offer got=%h want=%h", obs, exp);
    end else $display("ok   mdu_x0_offer %h", obs);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    exp = snap(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL mdu_x0_discarded got=%h want=%h", obs, exp);
    end else $display("ok   mdu_x0_discarded %h", obs);
    // Retire to x0 does not claim the port, so the held x3 drains.
    drive(1'b1, 5'd0, 32'hEE, 1'b0, 5'd0, 32'd0);
    exp = snap(1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b1, 5'd3);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL retire_x0_drain got=%h want=%h", obs, exp);
    end else $display("ok   retire_x0_drain %h", obs);
    drive(1'b1, 5'd0, 32'hEE, 1'b0, 5'd0, 32'd0);
    exp = snap(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL retire_x0_idle got=%h want=%h", obs, exp);
    end else $display("ok   retire_x0_idle %h", obs);
  endtask

  task automatic test_reset_held();
    logic [45:0] exp;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0DE);
    drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    #1;
    exp = '0;
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL reset_in_held got=%h want=%h", obs, exp);
    end else $display("ok   reset_in_held %h", obs);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp = snap(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL reset_held_release got=%h want=%h", obs, exp);
    end else $display("ok   reset_held_release %h", obs);
  endtask

  initial begin
    test_reset();
    test_retire();
    test_mdu_capture();
    test_starve();
    test_waw();
    test_x0();
    test_reset_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_writeback_arbiter
